// File: rtl/sram_template_2p_init.sv
// -----------------------------------------------------------------------------
// sram_template_2p_init
// Two-port set RAM with per-way write mask and a hardware init sequencer.
// After reset the sequencer zeroes one set per cycle for SETS cycles. Both user
// ports stay blocked until the array is clean.
//
// Ports:
//   clock, reset        sole clock, synchronous active-high reset
//   io_r_req_valid/ready, io_r_addr
//                       read request handshake (ready is low during init)
//   io_r_resp_valid     pulses one cycle after an accepted read
//   io_r_data           read data, way i at [(i+1)*WAY_BITS-1 : i*WAY_BITS]
//   io_w_en/ready, io_w_addr, io_w_data, io_w_mask
//                       write port with per-way enable (ready low during init)
//   io_init_done        high once the array has been zeroed
// -----------------------------------------------------------------------------
module sram_template_2p_init #(
    parameter int SETS      = 256,
    parameter int WAYS      = 4,
    parameter int WAY_BITS  = 20,
    parameter int BYPASS    = 1,
    parameter int HOLD_READ = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_r_req_valid,
    output logic                         io_r_req_ready,
    input  logic [$clog2(SETS)-1:0]      io_r_addr,
    output logic                         io_r_resp_valid,
    output logic [WAYS*WAY_BITS-1:0]     io_r_data,
    input  logic                         io_w_en,
    output logic                         io_w_ready,
    input  logic [$clog2(SETS)-1:0]      io_w_addr,
    input  logic [WAYS*WAY_BITS-1:0]     io_w_data,
    input  logic [WAYS-1:0]              io_w_mask,
    output logic                         io_init_done
);

    localparam int AW = $clog2(SETS);
    localparam int DW = WAYS * WAY_BITS;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state;
    logic [AW-1:0]     init_cnt;
    logic              done_q;

    logic [DW-1:0]     mem [SETS];

    logic              r_fire;
    logic              w_fire;
    logic [DW-1:0]     rd_merge_p0;
    logic              r_vld_p1;
    logic [DW-1:0]     r_data_p1;

    // done_q is the registered "port open" flag; it rises together with READY.
    assign r_fire = io_r_req_valid && done_q;
    assign w_fire = io_w_en && done_q;

    // Init sequencer: one set per cycle, counter parks at SETS-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            done_q   <= 1'b0;
        end else if (state == ST_INIT) begin
            if (init_cnt == AW'(SETS - 1)) begin
                state  <= ST_READY;
                done_q <= 1'b1;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end else begin
            state  <= ST_READY;
            done_q <= 1'b1;
        end
    end

    // Array storage. No writes on a reset edge: the array is re-zeroed anyway.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= '0;
            end else if (w_fire) begin
                for (int i = 0; i < WAYS; i++) begin
                    if (io_w_mask[i]) begin
                        mem[io_w_addr][i*WAY_BITS +: WAY_BITS] <= io_w_data[i*WAY_BITS +: WAY_BITS];
                    end
                end
            end
        end
    end

    // Stage p0: stored row, optionally overlaid with a same-cycle same-set write
    always_comb begin
        rd_merge_p0 = mem[io_r_addr];
        if (BYPASS != 0 && w_fire && (io_w_addr == io_r_addr)) begin
            for (int i = 0; i < WAYS; i++) begin
                if (io_w_mask[i]) begin
                    rd_merge_p0[i*WAY_BITS +: WAY_BITS] = io_w_data[i*WAY_BITS +: WAY_BITS];
                end
            end
        end
    end

    // Stage p1: registered response. Data register is cleared by reset so the
    // output is known-zero after reset in both hold modes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            r_vld_p1 <= r_fire;
            if (r_fire) begin
                r_data_p1 <= rd_merge_p0;
            end else if (HOLD_READ == 0) begin
                r_data_p1 <= '0;
            end
        end
    end

    assign io_r_req_ready  = done_q;
    assign io_w_ready      = done_q;
    assign io_init_done    = done_q;
    assign io_r_resp_valid = r_vld_p1;
    assign io_r_data       = r_data_p1;

endmodule

// File: tb/tb_sram_template_2p_init.sv
// -----------------------------------------------------------------------------
// tb_sram_template_2p_init
// Drives two instances from the same stimulus: A (BYPASS=1, HOLD_READ=1) and
// B (BYPASS=0, HOLD_READ=0). Expected read responses are pushed into one queue
// per instance when a read is issued; a monitor per instance pops and compares
// whenever that instance raises io_r_resp_valid.
// -----------------------------------------------------------------------------
module tb_sram_template_2p_init;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r_req_valid = 1'b0;
    logic [7:0]  r_addr = '0;
    logic        w_en = 1'b0;
    logic [7:0]  w_addr = '0;
    logic [79:0] w_data = '0;
    logic [3:0]  w_mask = '0;

    logic        rrdy_a, rv_a, wrdy_a, done_a;
    logic [79:0] rd_a;
    logic        rrdy_b, rv_b, wrdy_b, done_b;
    logic [79:0] rd_b;

    int total = 0;
    int bad   = 0;

    logic [79:0] q_a[$];
    logic [79:0] q_b[$];
    logic [79:0] pop_a, pop_b;

    always #5 clock = ~clock;

    sram_template_2p_init #(.BYPASS(1), .HOLD_READ(1)) dut_a (
        .clock(clock), .reset(reset),
        .io_r_req_valid(r_req_valid), .io_r_req_ready(rrdy_a), .io_r_addr(r_addr),
        .io_r_resp_valid(rv_a), .io_r_data(rd_a),
        .io_w_en(w_en), .io_w_ready(wrdy_a), .io_w_addr(w_addr),
        .io_w_data(w_data), .io_w_mask(w_mask), .io_init_done(done_a)
    );

    sram_template_2p_init #(.BYPASS(0), .HOLD_READ(0)) dut_b (
        .clock(clock), .reset(reset),
        .io_r_req_valid(r_req_valid), .io_r_req_ready(rrdy_b), .io_r_addr(r_addr),
        .io_r_resp_valid(rv_b), .io_r_data(rd_b),
        .io_w_en(w_en), .io_w_ready(wrdy_b), .io_w_addr(w_addr),
        .io_w_data(w_data), .io_w_mask(w_mask), .io_init_done(done_b)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [79:0] ways4(input logic [19:0] w3, input logic [19:0] w2,
                                         input logic [19:0] w1, input logic [19:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    // Monitors: sample on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (rv_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("unexpected_resp_a", 80'd1, 80'd0);
            end else begin
                pop_a = q_a.pop_front();
                check("resp_a", rd_a, pop_a);
            end
        end
        if (rv_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("unexpected_resp_b", 80'd1, 80'd0);
            end else begin
                pop_b = q_b.pop_front();
                check("resp_b", rd_b, pop_b);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        r_req_valid = 1'b0;
        w_en        = 1'b0;
        w_mask      = '0;
    endtask

    // Count edges after reset release until each instance reports init done.
    // Optionally inject a user write and read at a given init cycle.
    task automatic wait_init(input int inject_at, output int na, output int nb);
        na = 0;
        nb = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (c == inject_at + 1) idle_inputs();
            if (done_a === 1'b1 && na == 0) na = c;
            if (done_b === 1'b1 && nb == 0) nb = c;
            if (c == inject_at) begin
                w_en = 1'b1; w_addr = 8'd3; w_data = '1; w_mask = 4'hF;
                r_req_valid = 1'b1; r_addr = 8'd3;
                check("init_rreq_ready_a", {79'd0, rrdy_a}, 80'd0);
                check("init_wready_a", {79'd0, wrdy_a}, 80'd0);
            end
            if (na != 0 && nb != 0) break;
        end
    endtask

    task automatic read_set(input logic [7:0] a, input logic [79:0] ea, input logic [79:0] eb);
        r_req_valid = 1'b1;
        r_addr      = a;
        q_a.push_back(ea);
        q_b.push_back(eb);
        tick();
        r_req_valid = 1'b0;
    endtask

    task automatic write_set(input logic [7:0] a, input logic [79:0] d, input logic [3:0] m);
        w_en = 1'b1; w_addr = a; w_data = d; w_mask = m;
        tick();
        idle_inputs();
    endtask

    int na, nb;

    initial begin
        // Reset values
        reset = 1'b1;
        tick();
        tick();
        check("rst_rreq_ready", {78'd0, rrdy_a, rrdy_b}, 80'd0);
        check("rst_wready", {78'd0, wrdy_a, wrdy_b}, 80'd0);
        check("rst_resp_valid", {78'd0, rv_a, rv_b}, 80'd0);
        check("rst_init_done", {78'd0, done_a, done_b}, 80'd0);
        check("rst_data_a", rd_a, 80'd0);

        // Init length, with user requests injected at init cycle 10
        reset = 1'b0;
        wait_init(10, na, nb);
        check("init_len_a", 80'(na), 80'd256);
        check("init_len_b", 80'(nb), 80'd256);
        check("ready_after_init", {78'd0, rrdy_a, wrdy_a}, 80'd3);

        read_set(8'd0,   80'd0, 80'd0);
        read_set(8'd127, 80'd0, 80'd0);
        read_set(8'd255, 80'd0, 80'd0);
        read_set(8'd3,   80'd0, 80'd0);
        tick();

        // Masked write then read; response pulses for exactly one cycle
        write_set(8'd5, ways4(20'h44444, 20'h33333, 20'h22222, 20'h11111), 4'b0101);
        read_set(8'd5, ways4(20'h0, 20'h33333, 20'h0, 20'h11111),
                       ways4(20'h0, 20'h33333, 20'h0, 20'h11111));
        check("resp_pulse_hi", {78'd0, rv_a, rv_b}, 80'd3);
        tick();
        check("resp_pulse_lo", {78'd0, rv_a, rv_b}, 80'd0);

        // Same-cycle write/read to one set: bypass vs pre-write contents
        write_set(8'd9, {4{20'hAAAAA}}, 4'hF);
        w_en = 1'b1; w_addr = 8'd9; w_data = {4{20'h55555}}; w_mask = 4'b0011;
        read_set(8'd9, ways4(20'hAAAAA, 20'hAAAAA, 20'h55555, 20'h55555), {4{20'hAAAAA}});
        idle_inputs();
        // Back-to-back reads of previously written sets
        r_req_valid = 1'b1; r_addr = 8'd9;
        q_a.push_back(ways4(20'hAAAAA, 20'hAAAAA, 20'h55555, 20'h55555));
        q_b.push_back(ways4(20'hAAAAA, 20'hAAAAA, 20'h55555, 20'h55555));
        tick();
        read_set(8'd5, ways4(20'h0, 20'h33333, 20'h0, 20'h11111),
                       ways4(20'h0, 20'h33333, 20'h0, 20'h11111));
        tick();

        // Different-set write alongside a read stays independent
        w_en = 1'b1; w_addr = 8'd10; w_data = '1; w_mask = 4'hF;
        read_set(8'd11, 80'd0, 80'd0);
        idle_inputs();
        read_set(8'd10, '1, '1);
        tick();

        // Read-data hold
        write_set(8'd2, {4{20'hABCDE}}, 4'hF);
        read_set(8'd2, {4{20'hABCDE}}, {4{20'hABCDE}});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data_a", rd_a, {4{20'hABCDE}});
            check("nohold_data_b", rd_b, 80'd0);
            check("idle_valid", {78'd0, rv_a, rv_b}, 80'd0);
        end

        // Reset mid-operation, with a read presented on the reset edge
        write_set(8'd7, {4{20'h13579}}, 4'hF);
        reset = 1'b1;
        r_req_valid = 1'b1; r_addr = 8'd7;
        tick();
        r_req_valid = 1'b0;
        check("midrst_done", {78'd0, done_a, done_b}, 80'd0);
        check("midrst_resp_valid", {78'd0, rv_a, rv_b}, 80'd0);
        check("midrst_data_a", rd_a, 80'd0);
        reset = 1'b0;
        wait_init(-1, na, nb);
        check("reinit_len_a", 80'(na), 80'd256);
        check("reinit_len_b", 80'(nb), 80'd256);
        read_set(8'd7, 80'd0, 80'd0);
        tick();

        // Reset again at init cycle 100
        write_set(8'd7, {4{20'h2468A}}, 4'hF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        check("partial_init_done", {78'd0, done_a, done_b}, 80'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_init(-1, na, nb);
        check("rereinit_len_a", 80'(na), 80'd256);
        check("rereinit_len_b", 80'(nb), 80'd256);
        read_set(8'd7, 80'd0, 80'd0);
        read_set(8'd2, 80'd0, 80'd0);
        tick();
        tick();

        check("pending_a", 80'(q_a.size()), 80'd0);
        check("pending_b", 80'(q_b.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_template_2p_init.md
Name: sram_template_2p_init

Overview:
- Parametrised successor to the fixed 256x80 two-port masked set RAM wrapper.
- One read port and one write port, independent of each other.
- Per-way write mask.
- A hardware init sequencer zeroes every set after reset.
- A read request/response handshake with one-cycle latency.
- Optional same-cycle write-to-read bypass and read-data hold.
- Used by cache tag/meta arrays and predictor tables that must start from a known-zero state.

Parameters:
- SETS, 256, number of sets; power of two, >= 2.
- WAYS, 4, number of independently maskable ways per set.
- WAY_BITS, 20, width of one way.
- BYPASS, 1, when 1 a same-cycle same-set write is forwarded into the read response.
- HOLD_READ, 1, when 1 io_r_data holds the last response until the next accepted read; when 0 io_r_data reads 0 in cycles without io_r_resp_valid.

Ports:
- clock  input  1  sole clock.
- reset  input  1  synchronous active-high reset.
- io_r_req_valid  input  1  read request.
- io_r_req_ready  output  1  read port can accept; 0 during init.
- io_r_addr  input  log2(SETS)  read set index.
- io_r_resp_valid  output  1  pulses one cycle after an accepted read.
- io_r_data  output  WAYS*WAY_BITS  read data; way i occupies bits [(i+1)*WAY_BITS-1 : i*WAY_BITS].
- io_w_en  input  1  write request.
- io_w_ready  output  1  write port can accept; 0 during init.
- io_w_addr  input  log2(SETS)  write set index.
- io_w_data  input  WAYS*WAY_BITS  write data, same way layout as io_r_data.
- io_w_mask  input  WAYS  per-way write enable.
- io_init_done  output  1  high once init completes; stays high until the next reset.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: io_r_req_ready=0, io_w_ready=0, io_r_resp_valid=0, io_r_data=0, io_init_done=0. Init counter=0, FSM=INIT.
- FSM INIT:
  - Each cycle writes all-zero data with a full mask to set[counter], then counter increments.
  - When counter==SETS-1 is written, move to READY next cycle.
  - INIT lasts exactly SETS cycles after reset deassertion.
  - io_init_done, io_r_req_ready and io_w_ready rise in the first READY cycle.
- FSM READY: terminal until reset. io_r_req_ready=1, io_w_ready=1.
- Reset mid-init or mid-operation: returns to INIT with counter=0 and re-zeroes the whole array. Any pending response is dropped; io_r_resp_valid=0 in the cycle after reset.
- Requests during INIT:
  - io_w_en is ignored; the array is not modified by the user port.
  - io_r_req_valid is not accepted; no response is produced.
- Read:
  - Accepted when io_r_req_valid && io_r_req_ready; address sampled at that edge.
  - io_r_resp_valid=1 and io_r_data valid in the following cycle only.
  - Back-to-back reads are supported: one accepted read per cycle, one response per cycle.
- Write:
  - When io_w_en && io_w_ready, ways with io_w_mask[i]=1 are updated at the clock edge. Other ways are unchanged.
  - A write with mask=0 is a no-op.
- Same-cycle read and write to the same set:
  - BYPASS=1: response way i = written data if mask[i], else stored data.
  - BYPASS=0: response returns the pre-write contents.
  - Different sets: fully independent.
- Read of a set written in an earlier cycle always returns the new data.
- HOLD_READ=1: io_r_data keeps the last response value when no response is issued. Reset clears it to 0.
- Widths: address bits = log2(SETS); no wrap handling needed, since every address is legal.
- Init counter stops at SETS-1 and does not wrap.

Test Plan:
1. Default parameters; release reset, sample io_init_done per cycle -> low for 256 cycles, high on cycle 256. Read sets 0, 127 and 255 -> all return 0.
2. Write set 5, data = way pattern 0x11111/0x22222/0x33333/0x44444, mask=4'b0101; read set 5 next cycle -> ways0/2 = 0x11111/0x33333, ways1/3 = 0. io_r_resp_valid pulses exactly one cycle after acceptance.
3. Set 9 preloaded with all 0xAAAAA; same cycle write set 9 all 0x55555 mask=4'b0011 plus read set 9.
   - BYPASS=1 -> ways0/1 = 0x55555, ways2/3 = 0xAAAAA.
   - BYPASS=0 -> all 0xAAAAA.
4. Assert io_w_en (set 3, all-ones, full mask) and io_r_req_valid during INIT cycle 10 -> io_r_req_ready=0, no response. Set 3 reads 0 after init.
5. After writing set 7 with nonzero data, assert reset for 1 cycle mid-operation.
   - io_init_done drops, and INIT runs another 256 cycles.
   - Set 7 then reads 0.
   - Repeat with reset at INIT cycle 100 -> init still completes 256 cycles after that reset.
6. HOLD_READ=1: read set 2 (value 0xABCDE in all ways), then idle 5 cycles -> io_r_data stays at that value with io_r_resp_valid=0. HOLD_READ=0 -> io_r_data=0 during the idle cycles.
